// File: rtl/dice_cgra_tid_dispatcher.sv
// ============================================================================
// dice_cgra_tid_dispatcher: per-pipeline TID issue/retire controller for the
// DICE CGRA. Optional issue stall enabled by DICE_TID_DISPATCH_STALL_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dice_cgra_tid_dispatcher #(
  parameter int TOTAL_TID   = 512,
  parameter int TID_WIDTH   = $clog2(TOTAL_TID),
  parameter int MAX_LATENCY = 32,
  parameter int LAT_W       = $clog2(MAX_LATENCY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch_valid,
  output logic                 launch_ready,
  input  logic [TID_WIDTH-1:0] launch_tid_base,
  input  logic [TID_WIDTH:0]   launch_tid_count,
  input  logic [LAT_W-1:0]     launch_latency,
  input  logic                 abort,
  input  logic                 stall,
  output logic                 sr_clr,
  output logic [LAT_W-1:0]     sr_latency,
  output logic [TID_WIDTH-1:0] sr_in_tid,
  output logic                 sr_in_valid,
  input  logic                 sr_out_valid,
  input  logic                 sr_empty,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [TID_WIDTH:0]   issued_cnt,
  output logic [TID_WIDTH:0]   retired_cnt
);

  localparam logic [LAT_W-1:0] MAX_LAT = LAT_W'(MAX_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [TID_WIDTH-1:0] base_q;
  logic [TID_WIDTH:0]   count_q;
  logic [LAT_W-1:0]     lat_q;
  logic [TID_WIDTH:0]   issued_q;
  logic [TID_WIDTH:0]   retired_q;
  logic                 abort_q;
  logic                 stall_hold;
  logic                 issue_fire;
  logic                 last_issue;
  logic                 launch_fire;
  logic                 retire_fire;

`ifdef DICE_TID_DISPATCH_STALL_EN
  assign stall_hold = stall;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign stall_hold   = 1'b0;
`endif

  assign launch_fire = (state == S_IDLE) && launch_valid;
  assign issue_fire  = (state == S_ISSUE) && !stall_hold;
  assign last_issue  = issue_fire && (issued_q == count_q - (TID_WIDTH + 1)'(1));
  // Retires beyond the launched count are dropped so the counter saturates.
  assign retire_fire = ((state == S_ISSUE) || (state == S_DRAIN)) &&
                       sr_out_valid && (retired_q < count_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (launch_valid) next_state = S_CFG;
      S_CFG: begin
        if (abort)                next_state = S_ABORT;
        else if (count_q == '0)   next_state = S_DONE;
        else                      next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort)                next_state = S_ABORT;
        else if (last_issue)      next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                                   next_state = S_ABORT;
        else if ((retired_q == count_q) && sr_empty) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      S_ABORT: next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      count_q   <= '0;
      lat_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      abort_q   <= 1'b0;
    end else if (launch_fire) begin
      base_q    <= launch_tid_base;
      count_q   <= launch_tid_count;
      lat_q     <= (launch_latency > MAX_LAT) ? MAX_LAT : launch_latency;
      issued_q  <= '0;
      retired_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      if (issue_fire)        issued_q  <= issued_q + 1'b1;
      if (retire_fire)       retired_q <= retired_q + 1'b1;
      if (state == S_ABORT)  abort_q   <= 1'b1;
    end
  end

  assign launch_ready = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign sr_clr       = (state == S_CFG) || (state == S_ABORT);
  assign sr_latency   = lat_q;
  assign sr_in_valid  = issue_fire;
  // TID space is a power of two, so truncating the sum gives the wrap.
  assign sr_in_tid    = issue_fire ? (base_q + issued_q[TID_WIDTH-1:0]) : '0;
  assign done         = (state == S_DONE);
  assign aborted      = (state == S_DONE) && abort_q;
  assign issued_cnt   = issued_q;
  assign retired_cnt  = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_dice_cgra_tid_dispatcher.sv
// ============================================================================
// tb_dice_cgra_tid_dispatcher: directed table-driven bench for the TID
// dispatcher. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dice_cgra_tid_dispatcher;

  logic       clk;
  logic       rst;
  logic       launch_valid;
  logic       launch_ready;
  logic [8:0] launch_tid_base;
  logic [9:0] launch_tid_count;
  logic [5:0] launch_latency;
  logic       abort;
  logic       stall;
  logic       sr_clr;
  logic [5:0] sr_latency;
  logic [8:0] sr_in_tid;
  logic       sr_in_valid;
  logic       sr_out_valid;
  logic       sr_empty;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [9:0] issued_cnt;
  logic [9:0] retired_cnt;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [8:0]      base;
    logic [9:0]      cnt;
    logic [5:0]      lat;
    logic [5:0]      lat_exp;
    logic [3:0][8:0] tids;
  } kvec_t;

  kvec_t vecs [4];

  dice_cgra_tid_dispatcher dut (
    .clk              (clk),
    .rst              (rst),
    .launch_valid     (launch_valid),
    .launch_ready     (launch_ready),
    .launch_tid_base  (launch_tid_base),
    .launch_tid_count (launch_tid_count),
    .launch_latency   (launch_latency),
    .abort            (abort),
    .stall            (stall),
    .sr_clr           (sr_clr),
    .sr_latency       (sr_latency),
    .sr_in_tid        (sr_in_tid),
    .sr_in_valid      (sr_in_valid),
    .sr_out_valid     (sr_out_valid),
    .sr_empty         (sr_empty),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted),
    .issued_cnt       (issued_cnt),
    .retired_cnt      (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic kvec_t mk(input int b, input int c, input int l, input int le,
                               input int t0, input int t1, input int t2, input int t3);
    kvec_t v;
    v.base    = 9'(b);
    v.cnt     = 10'(c);
    v.lat     = 6'(l);
    v.lat_exp = 6'(le);
    v.tids[0] = 9'(t0);
    v.tids[1] = 9'(t1);
    v.tids[2] = 9'(t2);
    v.tids[3] = 9'(t3);
    return v;
  endfunction

  task automatic launch(input int b, input int c, input int l);
    cyc();
    launch_valid     = 1'b1;
    launch_tid_base  = 9'(b);
    launch_tid_count = 10'(c);
    launch_latency   = 6'(l);
    #3;
    chk("launch_ready", int'(launch_ready), 1);
  endtask

  task automatic run_kernel(input kvec_t v);
    int rets;
    rets = 0;
    launch(int'(v.base), int'(v.cnt), int'(v.lat));
    cyc();
    launch_valid = 1'b0;
    #3;
    chk("cfg_sr_clr", int'(sr_clr), 1);
    chk("cfg_sr_latency", int'(sr_latency), int'(v.lat_exp));
    chk("cfg_busy", int'(busy), 1);
    for (int i = 0; i < int'(v.cnt); i++) begin
      cyc();
      sr_out_valid = (i >= int'(v.lat_exp));
      if (sr_out_valid) rets++;
      #3;
      chk("issue_valid", int'(sr_in_valid), 1);
      chk("issue_tid", int'(sr_in_tid), int'(v.tids[i]));
    end
    for (int k = 0; k < 40 && rets < int'(v.cnt); k++) begin
      cyc();
      sr_out_valid = 1'b1;
      rets++;
      #3;
      chk("drain_valid", int'(sr_in_valid), 0);
      chk("drain_done", int'(done), 0);
    end
    cyc();
    sr_out_valid = 1'b0;
    sr_empty     = 1'b1;
    #3;
    chk("pre_done_retired", int'(retired_cnt), int'(v.cnt));
    chk("pre_done_done", int'(done), 0);
    cyc();
    sr_empty = 1'b0;
    #3;
    chk("done", int'(done), 1);
    chk("done_aborted", int'(aborted), 0);
    chk("done_issued", int'(issued_cnt), int'(v.cnt));
    chk("done_retired", int'(retired_cnt), int'(v.cnt));
    cyc();
    #3;
    chk("post_ready", int'(launch_ready), 1);
    chk("post_done", int'(done), 0);
    chk("post_latency_hold", int'(sr_latency), int'(v.lat_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    launch_valid = 1'b0;
    launch_tid_base = '0;
    launch_tid_count = '0;
    launch_latency = '0;
    abort = 1'b0;
    stall = 1'b0;
    sr_out_valid = 1'b0;
    sr_empty = 1'b0;

    vecs[0] = mk(5,   4, 3,  3,  5,   6,   7, 8);
    vecs[1] = mk(510, 4, 40, 32, 510, 511, 0, 1);
    vecs[2] = mk(511, 2, 1,  1,  511, 0,   0, 0);
    vecs[3] = mk(100, 1, 32, 32, 100, 0,   0, 0);

    // Reset state
    cyc();
    cyc();
    #3;
    chk("rst_ready", int'(launch_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sr_clr", int'(sr_clr), 0);
    chk("rst_sr_latency", int'(sr_latency), 0);
    chk("rst_sr_in_valid", int'(sr_in_valid), 0);
    chk("rst_sr_in_tid", int'(sr_in_tid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_issued", int'(issued_cnt), 0);
    cyc();
    rst = 1'b0;

    for (int v = 0; v < 4; v++) run_kernel(vecs[v]);

    // Zero-count kernel
    launch(3, 0, 7);
    cyc();
    launch_valid = 1'b0;
    #3;
    chk("zc_sr_clr", int'(sr_clr), 1);
    chk("zc_latency", int'(sr_latency), 7);
    chk("zc_valid_cfg", int'(sr_in_valid), 0);
    cyc();
    #3;
    chk("zc_done", int'(done), 1);
    chk("zc_aborted", int'(aborted), 0);
    chk("zc_issued", int'(issued_cnt), 0);
    chk("zc_valid_done", int'(sr_in_valid), 0);
    cyc();
    #3;
    chk("zc_ready", int'(launch_ready), 1);

    // Abort after two of ten issues
    launch(0, 10, 5);
    cyc();
    launch_valid = 1'b0;
    cyc();
    #3;
    chk("ab_tid0", int'(sr_in_tid), 0);
    cyc();
    abort = 1'b1;
    #3;
    chk("ab_tid1", int'(sr_in_tid), 1);
    cyc();
    abort = 1'b0;
    #3;
    chk("ab_sr_clr", int'(sr_clr), 1);
    chk("ab_valid", int'(sr_in_valid), 0);
    chk("ab_issued", int'(issued_cnt), 2);
    chk("ab_done_early", int'(done), 0);
    cyc();
    #3;
    chk("ab_done", int'(done), 1);
    chk("ab_aborted", int'(aborted), 1);
    cyc();
    #3;
    chk("ab_ready", int'(launch_ready), 1);
    chk("ab_aborted_clear", int'(aborted), 0);

    // Abort in IDLE is ignored
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    #3;
    chk("idle_abort_busy", int'(busy), 0);

    // Stall during issue
    launch(20, 3, 2);
    cyc();
    launch_valid = 1'b0;
    cyc();
    #3;
    chk("st_valid0", int'(sr_in_valid), 1);
    chk("st_tid0", int'(sr_in_tid), 20);
    cyc();
    stall = 1'b1;
    #3;
`ifdef DICE_TID_DISPATCH_STALL_EN
    chk("st_hold1", int'(sr_in_valid), 0);
`else
    chk("st_tid1", int'(sr_in_tid), 21);
`endif
    cyc();
    sr_out_valid = 1'b1;
    #3;
`ifdef DICE_TID_DISPATCH_STALL_EN
    chk("st_hold2", int'(sr_in_valid), 0);
    chk("st_hold_cnt", int'(issued_cnt), 1);
`else
    chk("st_tid2", int'(sr_in_tid), 22);
`endif
    cyc();
    stall = 1'b0;
    sr_out_valid = 1'b0;
    #3;
    chk("st_retire_in_stall", int'(retired_cnt), 1);
`ifdef DICE_TID_DISPATCH_STALL_EN
    chk("st_tid1_late", int'(sr_in_tid), 21);
`else
    chk("st_drain5", int'(sr_in_valid), 0);
`endif
    cyc();
    #3;
`ifdef DICE_TID_DISPATCH_STALL_EN
    chk("st_tid2_late", int'(sr_in_tid), 22);
`else
    chk("st_drain6", int'(sr_in_valid), 0);
`endif
    for (int k = 0; k < 3; k++) begin
      cyc();
      sr_out_valid = 1'b1;
    end
    cyc();
    sr_out_valid = 1'b0;
    sr_empty = 1'b1;
    #3;
    chk("st_retire_sat", int'(retired_cnt), 3);
    cyc();
    sr_empty = 1'b0;
    #3;
    chk("st_done", int'(done), 1);
    chk("st_issued", int'(issued_cnt), 3);

    // Reset in the middle of DRAIN
    launch(7, 2, 4);
    cyc();
    launch_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    #1;
    chk("mr_busy_before", int'(busy), 1);
    rst = 1'b1;
    #2;
    chk("mr_ready", int'(launch_ready), 1);
    chk("mr_busy", int'(busy), 0);
    chk("mr_latency", int'(sr_latency), 0);
    chk("mr_issued", int'(issued_cnt), 0);
    chk("mr_retired", int'(retired_cnt), 0);
    chk("mr_done", int'(done), 0);
    cyc();
    rst = 1'b0;
    sr_empty = 1'b1;
    sr_out_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #3;
      chk("mr_no_done", int'(done), 0);
    end
    sr_empty = 1'b0;
    sr_out_valid = 1'b0;
    run_kernel(mk(40, 2, 0, 0, 40, 41, 0, 0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
